// File: rtl/fp_pkg.sv
// fp_pkg: constants and types shared by the integer-to-float converter and
// the FPU adder.
//   FPU word: [31] sign, [30:21] biased exponent, [20:0] fraction with the
//   leading 1 implied.
//   status_t : result status reported alongside every FPU result.
//   ST_*     : 4-bit controller state encodings.
package fp_pkg;

    localparam int EXP_W       = 10;
    localparam int FRAC_W      = 21;
    localparam int FP_EXP_BIAS = 511;

    typedef enum logic [1:0] {
        OVERFLOW  = 2'd0,
        UNDERFLOW = 2'd1,
        EXACT     = 2'd2,
        INEXACT   = 2'd3
    } status_t;

    localparam int STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_MAGNITUDE = 4'd1;
    localparam state_t ST_NORMALIZE = 4'd2;
    localparam state_t ST_PACK      = 4'd3;

endpackage

// File: rtl/int_to_fp_round.sv
// int_to_fp_round: combinational fraction/exponent finishing stage.
//   exp_in   : exponent of the normalized magnitude
//   mag      : normalized magnitude with the leading 1 stripped (bits 30:0)
//   exp_out  : exponent after any rounding carry
//   frac_out : stored fraction
//   inexact  : a nonzero bit was discarded
// Macro INT_TO_FP_ROUND_EN selects round-to-nearest-even; otherwise the low
// ten magnitude bits are truncated.
module int_to_fp_round
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [30:0]       mag,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              inexact
);

    assign inexact = |mag[9:0];

`ifdef INT_TO_FP_ROUND_EN
    logic              round_up;
    logic [FRAC_W:0]   sum;

    // Guard is bit 9; ties (guard set, nothing below) go to the even fraction.
    assign round_up = mag[9] & ((|mag[8:0]) | mag[10]);
    assign sum      = {1'b0, mag[30:10]} + {{FRAC_W{1'b0}}, round_up};
    // A carry out of the fraction leaves it all-zero; bump the exponent.
    assign frac_out = sum[FRAC_W-1:0];
    assign exp_out  = exp_in + {{(EXP_W-1){1'b0}}, sum[FRAC_W]};
`else
    assign frac_out = mag[30:10];
    assign exp_out  = exp_in;
`endif

endmodule

// File: rtl/int_to_fp.sv
// int_to_fp: sequential signed 32-bit integer to FPU-word converter.
//   clock_100Khz : clock, rising edge
//   reset        : asynchronous, active-low
//   start        : conversion request, sampled only when idle
//   int_in       : two's-complement operand
//   busy         : high while a conversion is in flight
//   done         : one-cycle pulse when data_out/status_out update
//   data_out     : {sign, exponent[9:0], fraction[20:0]}
//   status_out   : EXACT or INEXACT
// Normalization shifts one bit per cycle, so latency is 4 + leading zeros.
// Optional macro INT_TO_FP_ROUND_EN enables round-to-nearest-even.
module int_to_fp
    import fp_pkg::*;
(
    input  logic        clock_100Khz,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output status_t     status_out
);

    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(FP_EXP_BIAS + 31);

    state_t             state;
    logic [31:0]        operand;
    logic               sign;
    logic [31:0]        mag;
    logic [EXP_W-1:0]   exp;

    logic [31:0]        abs_val;
    logic [EXP_W-1:0]   rnd_exp;
    logic [FRAC_W-1:0]  rnd_frac;
    logic               rnd_inexact;

    // 0x80000000 negates to itself, which is exactly 2^31 as unsigned.
    assign abs_val = operand[31] ? (~operand + 32'd1) : operand;
    assign busy    = (state != ST_IDLE);

    int_to_fp_round u_round (
        .exp_in   (exp),
        .mag      (mag[30:0]),
        .exp_out  (rnd_exp),
        .frac_out (rnd_frac),
        .inexact  (rnd_inexact)
    );

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            operand    <= '0;
            sign       <= 1'b0;
            mag        <= '0;
            exp        <= '0;
            done       <= 1'b0;
            data_out   <= '0;
            status_out <= EXACT;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        operand <= int_in;
                        state   <= ST_MAGNITUDE;
                    end
                end
                ST_MAGNITUDE: begin
                    sign  <= operand[31];
                    mag   <= abs_val;
                    exp   <= EXP_INIT;
                    state <= (abs_val == '0) ? ST_PACK : ST_NORMALIZE;
                end
                ST_NORMALIZE: begin
                    if (mag[31]) begin
                        state <= ST_PACK;
                    end else begin
                        mag <= mag << 1;
                        exp <= exp - 1'b1;
                    end
                end
                ST_PACK: begin
                    // Zero has no leading 1 to hide, so it gets the all-zero word.
                    if (mag == '0) begin
                        data_out   <= '0;
                        status_out <= EXACT;
                    end else begin
                        data_out   <= {sign, rnd_exp, rnd_frac};
                        status_out <= rnd_inexact ? INEXACT : EXACT;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/int_to_fp.md
INT_TO_FP -- requirements
Module: int_to_fp

Interface
REQ-001 SHALL have port clock_100Khz  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port int_in  input  32  signed two's-complement operand.
REQ-005 SHALL have port busy  output  1  high in every state except IDLE.
REQ-006 SHALL have port done  output  1  one-cycle pulse when data_out/status_out become valid.
REQ-007 SHALL have port data_out  output  32  FPU word: [31] sign, [30:21] biased exponent, [20:0] fraction (hidden 1 not stored).
REQ-008 SHALL have port status_out  output  status_t  result status (OVERFLOW, UNDERFLOW, EXACT, INEXACT).
REQ-009 SHALL have parameter none; exponent bias is package constant FP_EXP_BIAS = 511.

Function
REQ-010 SHALL implement states IDLE, MAGNITUDE, NORMALIZE, PACK; encoding is the shared state enum width (4 bits).
REQ-011 SHALL, in IDLE with start=1, latch int_in and go to MAGNITUDE; start=0 stays IDLE.
REQ-012 SHALL ignore start while busy=1; latched operand is not disturbed by int_in changes.
REQ-013 SHALL, in MAGNITUDE, register sign=int_in[31], 32-bit unsigned magnitude (abs; 0x80000000 -> 2^31), exponent = FP_EXP_BIAS+31.
REQ-014 SHALL go from MAGNITUDE to PACK directly when magnitude is 0, otherwise to NORMALIZE.
REQ-015 SHALL, in NORMALIZE, shift magnitude left one bit and decrement exponent per cycle while bit 31 is 0; go to PACK when bit 31 is 1.
REQ-016 SHALL, in PACK, write data_out = {sign, exponent, magnitude[30:10]}, set status_out, pulse done=1, return to IDLE.
REQ-017 SHALL report zero input as data_out=0x00000000, status EXACT.
REQ-018 SHALL report INEXACT when magnitude[9:0] is nonzero at PACK, else EXACT; OVERFLOW/UNDERFLOW are never produced (exponent range 511..542).
REQ-019 SHALL have latency: done asserted on rising edge 4+L counting the start-sampling edge as 1, L = leading-zero count of magnitude; 3 for zero input.
REQ-020 SHALL hold data_out and status_out stable from done until the next PACK.
REQ-021 SHALL accept a new start in the cycle after done (back-to-back operation).

Reset
REQ-022 SHALL, on reset low at any time including mid-conversion, go to IDLE immediately: busy=0, done=0, data_out=0, status_out=EXACT, internal registers 0.
REQ-023 SHALL not sample start in the first edge after reset deasserts unless state is IDLE (it always is).

Configuration
REQ-024 SHALL provide macro INT_TO_FP_ROUND_EN.
REQ-025 SHALL, with INT_TO_FP_ROUND_EN defined, round to nearest-even on magnitude[9:0] in PACK; fraction carry-out sets fraction=0 and exponent+1; status INEXACT if any discarded bit nonzero.
REQ-026 SHALL, without INT_TO_FP_ROUND_EN, truncate (discard magnitude[9:0]); latency identical in both builds.

Structure
REQ-027 SHALL take status_t, the state enum, FP_EXP_BIAS, field widths (EXP_W=10, FRAC_W=21) from shared package fp_pkg, also used by the FPU adder.
REQ-028 SHALL place rounding logic in one combinational sub-module int_to_fp_round (compiled to pass-through truncation when macro absent).

Verification
REQ-029 SHALL cover int_in=0x00000001 -> data_out=0x3FE00000, EXACT, done on edge 35.
REQ-030 SHALL cover int_in=0xFFFFFFFF (-1) -> 0xBFE00000, EXACT; int_in=3 -> 0x40100000, EXACT.
REQ-031 SHALL cover int_in=0x80000000 -> 0xC3C00000, EXACT, done on edge 4.
REQ-032 SHALL cover int_in=0x7FFFFFFF -> 0x43BFFFFF INEXACT without macro; 0x43C00000 INEXACT with INT_TO_FP_ROUND_EN.
REQ-033 SHALL cover int_in=0 -> 0x00000000, EXACT, done on edge 3; start pulses while busy ignored.
REQ-034 SHALL cover reset asserted during NORMALIZE -> outputs cleared at once, no done pulse; next start converts correctly.
